// File: rtl/vrased_reset_seq_if.sv
// Bundle between the VRASED monitor set / CPU core and the reset sequencer.
// The violation lines and pc are level signals sampled on every clk edge.
// There is no valid/ready pairing. A violation counts on any edge where
// |viol is high, and the sequencer never back-pressures the monitors.
interface vrased_reset_seq_if #(
  parameter int CNT_W = 8
);
  logic [5:0]       viol;
  logic [15:0]      pc;
  logic             cause_clr;
  logic             cpu_rst;
  logic [6:0]       viol_cause;
  logic [15:0]      viol_pc;
  logic [CNT_W-1:0] viol_count;
  logic             busy;
  logic [1:0]       state_dbg;

  // Monitors / CPU side: drives the violation lines and pc, consumes the reset.
  modport master (
    output viol, pc, cause_clr,
    input  cpu_rst, viol_cause, viol_pc, viol_count, busy, state_dbg
  );

  // Sequencer side.
  modport slave (
    input  viol, pc, cause_clr,
    output cpu_rst, viol_cause, viol_pc, viol_count, busy, state_dbg
  );
endinterface

// File: rtl/vrased_reset_seq.sv
// VRASED reset sequencer.
// It turns any monitor violation into a fixed-width CPU reset pulse.
// It then checks that the CPU restarts at RESET_HANDLER.
// It records the cause, the pc and an event count for post-mortem readout.
module vrased_reset_seq #(
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          HOLD_CYCLES   = 8,
  parameter int          FETCH_TIMEOUT = 16,
  parameter int          CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  vrased_reset_seq_if.slave    bus
);

  localparam int HW = (HOLD_CYCLES   > 1) ? $clog2(HOLD_CYCLES)   : 1;
  localparam int FW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [FW-1:0] FETCH_LOAD = FW'(FETCH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ASSERT     = 2'd1,
    WAIT_FETCH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             busy_q, busy_d;
  logic [6:0]       cause_q, cause_d;
  logic [15:0]      vpc_q, vpc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [FW-1:0]    fetch_q, fetch_d;

  // Sticky values as seen by this cycle's update.
  // In IDLE, cause_clr wipes the values before any new violation is applied.
  logic [6:0]       cause_base;
  logic [CNT_W-1:0] count_base;
  logic [CNT_W-1:0] count_inc;
  logic             any_viol;

  // Next-state, counter and sticky-record computation.
  always_comb begin
    state_d   = state_q;
    cpu_rst_d = cpu_rst_q;
    cause_d   = cause_q;
    vpc_d     = vpc_q;
    count_d   = count_q;
    hold_d    = hold_q;
    fetch_d   = fetch_q;

    any_viol   = |bus.viol;
    cause_base = cause_q;
    count_base = count_q;
    if (state_q == IDLE && bus.cause_clr) begin
      cause_base = '0;
      count_base = '0;
    end
    // The event counter saturates at all-ones and never wraps.
    count_inc = (count_base == {CNT_W{1'b1}}) ? count_base : count_base + 1'b1;

    unique case (state_q)
      IDLE: begin
        cause_d   = cause_base;
        count_d   = count_base;
        cpu_rst_d = 1'b0;
        if (any_viol) begin
          state_d   = ASSERT;
          cpu_rst_d = 1'b1;
          cause_d   = cause_base | {1'b0, bus.viol};
          vpc_d     = bus.pc;
          count_d   = count_inc;
          hold_d    = HOLD_LOAD;
        end
      end
      ASSERT: begin
        // Late violations only add cause bits; the window stays fixed.
        cause_d = cause_q | {1'b0, bus.viol};
        if (hold_q == '0) begin
          state_d   = WAIT_FETCH;
          cpu_rst_d = 1'b0;
          fetch_d   = FETCH_LOAD;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      WAIT_FETCH: begin
        cpu_rst_d = 1'b0;
        if (any_viol) begin
          state_d   = ASSERT;
          cpu_rst_d = 1'b1;
          cause_d   = cause_q | {1'b0, bus.viol};
          vpc_d     = bus.pc;
          count_d   = count_inc;
          hold_d    = HOLD_LOAD;
        end else if (bus.pc == RESET_HANDLER) begin
          state_d = IDLE;
        end else if (fetch_q == '0) begin
          // The CPU never reached the handler, so the event is re-issued
          // as a fetch-timeout violation.
          state_d   = ASSERT;
          cpu_rst_d = 1'b1;
          cause_d   = cause_q | 7'h40;
          vpc_d     = bus.pc;
          count_d   = count_inc;
          hold_d    = HOLD_LOAD;
        end else begin
          fetch_d = fetch_q - 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        cpu_rst_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any sequence back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cpu_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      cause_q   <= '0;
      vpc_q     <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      fetch_q   <= '0;
    end else begin
      state_q   <= state_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      cause_q   <= cause_d;
      vpc_q     <= vpc_d;
      count_q   <= count_d;
      hold_q    <= hold_d;
      fetch_q   <= fetch_d;
    end
  end

  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.busy       = busy_q;
  assign bus.viol_cause = cause_q;
  assign bus.viol_pc    = vpc_q;
  assign bus.viol_count = count_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_vrased_reset_seq.sv
// Directed bench for vrased_reset_seq.
// It runs a default instance and a CNT_W=2 instance from the same stimulus.
module tb_vrased_reset_seq;

  logic        clk;
  logic        reset;
  logic [5:0]  viol;
  logic [15:0] pc;
  logic        cause_clr;

  int n_vec;
  int n_err;

  vrased_reset_seq_if #(.CNT_W(8)) if1 ();
  vrased_reset_seq_if #(.CNT_W(2)) if2 ();

  assign if1.viol      = viol;
  assign if1.pc        = pc;
  assign if1.cause_clr = cause_clr;
  assign if2.viol      = viol;
  assign if2.pc        = pc;
  assign if2.cause_clr = cause_clr;

  vrased_reset_seq #(.CNT_W(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  vrased_reset_seq #(.CNT_W(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2.slave)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; outputs are observed 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Count the cycles for which cpu_rst is high.
  // Optionally inject a viol pattern once inj_at high cycles have been seen.
  task automatic measure_hi(input int inj_at, input logic [5:0] inj_val, output int w);
    w = 0;
    while (if1.cpu_rst === 1'b1 && w < 30) begin
      viol = (w == inj_at) ? inj_val : 6'h00;
      w++;
      tick();
    end
    viol = 6'h00;
  endtask

  int w;

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    viol      = 6'h00;
    pc        = 16'h0000;
    cause_clr = 1'b0;

    // 1: reset then idle
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    check("t1_cpu_rst", 32'(if1.cpu_rst), 32'd0);
    check("t1_busy",    32'(if1.busy), 32'd0);
    check("t1_cause",   32'(if1.viol_cause), 32'h00);
    check("t1_count",   32'(if1.viol_count), 32'd0);
    check("t1_vpc",     32'(if1.viol_pc), 32'h0000);
    check("t1_state",   32'(if1.state_dbg), 32'd0);

    // 2: single AC violation, clean restart
    viol = 6'b000010;
    pc   = 16'hE123;
    tick();
    viol = 6'h00;
    pc   = 16'h1234;
    check("t2_rst_rise", 32'(if1.cpu_rst), 32'd1);
    measure_hi(-1, 6'h00, w);
    check("t2_width", 32'(w), 32'd8);
    check("t2_cause", 32'(if1.viol_cause), 32'h02);
    check("t2_vpc",   32'(if1.viol_pc), 32'hE123);
    check("t2_count", 32'(if1.viol_count), 32'd1);
    check("t2_busy_wf", 32'(if1.busy), 32'd1);
    tick();
    pc = 16'h0000;
    tick();
    check("t2_idle_busy", 32'(if1.busy), 32'd0);
    check("t2_idle_rst",  32'(if1.cpu_rst), 32'd0);

    // 3: second violation during ASSERT merges cause only
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    viol = 6'b000001;
    pc   = 16'hE456;
    tick();
    viol = 6'h00;
    pc   = 16'hE000;
    measure_hi(3, 6'b010000, w);
    check("t3_width", 32'(w), 32'd8);
    check("t3_cause", 32'(if1.viol_cause), 32'h11);
    check("t3_count", 32'(if1.viol_count), 32'd1);
    check("t3_vpc",   32'(if1.viol_pc), 32'hE456);

    // 4: pc parked away from the handler -> fetch timeout
    w = 0;
    while (if1.cpu_rst === 1'b0 && w < 40) begin
      w++;
      tick();
    end
    check("t4_timeout_cycles", 32'(w), 32'd16);
    check("t4_rst",   32'(if1.cpu_rst), 32'd1);
    check("t4_cause", 32'(if1.viol_cause), 32'h51);
    check("t4_count", 32'(if1.viol_count), 32'd2);
    check("t4_vpc",   32'(if1.viol_pc), 32'hE000);
    measure_hi(-1, 6'h00, w);
    check("t4_width", 32'(w), 32'd8);
    pc = 16'h0000;
    tick();
    check("t4_idle_busy", 32'(if1.busy), 32'd0);

    // 5: cause_clr behaviour
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    check("t5_clr_cause", 32'(if1.viol_cause), 32'h00);
    check("t5_clr_count", 32'(if1.viol_count), 32'd0);
    check("t5_clr_vpc_kept", 32'(if1.viol_pc), 32'hE000);
    viol = 6'b000100;
    pc   = 16'h1000;
    tick();
    viol = 6'h00;
    measure_hi(-1, 6'h00, w);
    pc = 16'h0000;
    tick();
    check("t5_pre_cause", 32'(if1.viol_cause), 32'h04);
    cause_clr = 1'b1;
    viol      = 6'b100000;
    pc        = 16'hABCD;
    tick();
    viol      = 6'h00;
    check("t5_cv_cause", 32'(if1.viol_cause), 32'h20);
    check("t5_cv_count", 32'(if1.viol_count), 32'd1);
    check("t5_cv_vpc",   32'(if1.viol_pc), 32'hABCD);
    check("t5_cv_rst",   32'(if1.cpu_rst), 32'd1);
    tick();
    cause_clr = 1'b0;
    check("t5_assert_clr_cause", 32'(if1.viol_cause), 32'h20);
    check("t5_assert_clr_count", 32'(if1.viol_count), 32'd1);
    measure_hi(-1, 6'h00, w);
    pc = 16'h0000;
    tick();

    // 6: counter saturation on the CNT_W=2 instance, then a mid-ASSERT reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      viol = 6'b001000;
      pc   = 16'hF000;
      tick();
      viol = 6'h00;
      measure_hi(-1, 6'h00, w);
      pc = 16'h0000;
      tick();
      check($sformatf("t6_count2_e%0d", e), 32'(if2.viol_count), (e > 3) ? 32'd3 : 32'(e));
      check($sformatf("t6_count8_e%0d", e), 32'(if1.viol_count), 32'(e));
    end
    viol = 6'b001000;
    pc   = 16'hF000;
    tick();
    viol = 6'h00;
    repeat (3) tick();
    check("t6_mid_rst2", 32'(if2.cpu_rst), 32'd1);
    reset = 1'b1;
    tick();
    check("t6_abort_rst2",   32'(if2.cpu_rst), 32'd0);
    check("t6_abort_busy2",  32'(if2.busy), 32'd0);
    check("t6_abort_cause2", 32'(if2.viol_cause), 32'h00);
    check("t6_abort_vpc2",   32'(if2.viol_pc), 32'h0000);
    check("t6_abort_count2", 32'(if2.viol_count), 32'd0);
    check("t6_abort_rst1",   32'(if1.cpu_rst), 32'd0);
    check("t6_abort_count1", 32'(if1.viol_count), 32'd0);
    check("t6_abort_state1", 32'(if1.state_dbg), 32'd0);
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
